gc_dram_refresh_ctrl: RTL and testbench

//  Front-end controller for the 128x64 gain-cell DRAM macro. Sits directly upstream of the macro.

---
 rtl/gc_dram_pkg.sv | 15 +
 rtl/gc_dram_refresh_ctrl_if.sv | 30 +++
 rtl/gc_ref_timer.sv | 30 +++
 rtl/gc_dram_refresh_ctrl.sv | 124 ++++++++++++
 tb/tb_gc_dram_refresh_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gc_dram_pkg.sv
// Shared constants, types and helpers for the gain-cell DRAM refresh front-end.
package gc_dram_pkg;
  localparam int ROWS      = 128;
  localparam int WIDTH     = 64;
  localparam int AW        = $clog2(ROWS);
  localparam int RETENTION = 5000;

  typedef enum logic [1:0] {IDLE, REF_RD, REF_WB} ref_state_t;
  typedef logic [AW-1:0]    addr_t;
  typedef logic [WIDTH-1:0] data_t;

  function automatic addr_t next_row(input addr_t r);
    return (r == addr_t'(ROWS - 1)) ? '0 : r + addr_t'(1);
  endfunction
endpackage

// File: rtl/gc_dram_refresh_ctrl_if.sv
// User request/response and macro-side signals of the refresh controller; the controller
// takes the slave modport, the user plus macro model the master modport.
interface gc_dram_refresh_ctrl_if;
  import gc_dram_pkg::*;

  logic  u_req_valid;
  logic  u_req_ready;
  logic  u_we;
  addr_t u_addr;
  data_t u_wdata;
  logic  u_rvalid;
  data_t u_rdata;
  logic  mem_re;
  logic  mem_we;
  addr_t mem_raddr;
  addr_t mem_waddr;
  data_t mem_in;
  data_t mem_rd;
  logic  ref_busy;

  modport slave (
    input  u_req_valid, u_we, u_addr, u_wdata, mem_rd,
    output u_req_ready, u_rvalid, u_rdata, mem_re, mem_we, mem_raddr, mem_waddr, mem_in, ref_busy
  );

  modport master (
    output u_req_valid, u_we, u_addr, u_wdata, mem_rd,
    input  u_req_ready, u_rvalid, u_rdata, mem_re, mem_we, mem_raddr, mem_waddr, mem_in, ref_busy
  );
endinterface

// File: rtl/gc_ref_timer.sv
// Refresh interval counter (tick every REF_PERIOD cycles, first after REF_PERIOD) and row pointer;
// pointer steps on advance and wraps ROWS-1 -> 0. No backpressure: the tick is never held off.
module gc_ref_timer
  import gc_dram_pkg::*;
#(
  parameter int REF_PERIOD = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  advance,
  output logic  tick,
  output addr_t ref_row
);
  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REF_PERIOD - 1);

  logic [TW-1:0] timer;

  assign tick = (timer == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer   <= RELOAD;
      ref_row <= '0;
    end else begin
      timer <= tick ? RELOAD : timer - 1'b1;
      if (advance) ref_row <= next_row(ref_row);
    end
  end
endmodule

// File: rtl/gc_dram_refresh_ctrl.sv
// Arbitrates user reads/writes against row refresh (read, write back next cycle); read data 2 cycles after accept.
// Refresh always wins: user stalls at most 3 cycles per slot. GC_REF_SKIP_EN skips refresh of user-written rows.
module gc_dram_refresh_ctrl
  import gc_dram_pkg::*;
#(
  parameter int REF_PERIOD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gc_dram_refresh_ctrl_if.slave  bus
);
  // A skipped slot doubles the worst-case row age, so bound it at elaboration.
  if (2 * ROWS * REF_PERIOD >= RETENTION) begin : g_retention_chk
    $error("gc_dram_refresh_ctrl: REF_PERIOD too long for macro retention");
  end

  ref_state_t state, state_nxt;
  logic       ref_pending, pending_clr, advance, tick, skip, accept;
  addr_t      ref_row;
  logic       rd_pend, rvalid_q;
  data_t      rdata_q;
  logic       mem_re, mem_we;
  addr_t      mem_raddr, mem_waddr;
  data_t      mem_in;

  gc_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .tick    (tick),
    .ref_row (ref_row)
  );

`ifdef GC_REF_SKIP_EN
  logic [ROWS-1:0] written;

  assign skip = (state == IDLE) && ref_pending && written[ref_row];

  // A user write landing in the skipped slot re-arms the flag (set wins over clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written <= '0;
    end else begin
      if (skip) written[ref_row] <= 1'b0;
      if (accept && bus.u_we) written[bus.u_addr] <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  assign bus.u_req_ready = (state == IDLE) && (!ref_pending || skip);
  assign accept          = bus.u_req_valid && bus.u_req_ready;
  assign bus.ref_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ref_pending <= 1'b0;
      rd_pend     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      ref_pending <= (ref_pending && !pending_clr) || tick;
      rd_pend     <= accept && !bus.u_we;
      rvalid_q    <= rd_pend;
      if (rd_pend) rdata_q <= bus.mem_rd;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_clr = 1'b0;
    advance     = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_in      = '0;
    case (state)
      IDLE: begin
        if (skip) begin
          pending_clr = 1'b1;
          advance     = 1'b1;
        end else if (ref_pending) begin
          state_nxt = REF_RD;
        end
        if (accept) begin
          if (bus.u_we) begin
            mem_we    = 1'b1;
            mem_waddr = bus.u_addr;
            mem_in    = bus.u_wdata;
          end else begin
            mem_re    = 1'b1;
            mem_raddr = bus.u_addr;
          end
        end
      end
      REF_RD: begin
        mem_re      = 1'b1;
        mem_raddr   = ref_row;
        pending_clr = 1'b1;
        state_nxt   = REF_WB;
      end
      REF_WB: begin
        mem_we    = 1'b1;
        mem_waddr = ref_row;
        mem_in    = bus.mem_rd;
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_raddr = mem_raddr;
  assign bus.mem_waddr = mem_waddr;
  assign bus.mem_in    = mem_in;
  assign bus.u_rvalid  = rvalid_q;
  assign bus.u_rdata   = rdata_q;
endmodule

// File: tb/tb_gc_dram_refresh_ctrl.sv
// Bench for gc_dram_refresh_ctrl: macro model with age tracking plus a slot-schedule reference model.
`timescale 1ns/1ps
module tb_gc_dram_refresh_ctrl;
  import gc_dram_pkg::*;

  localparam int RP = 16;
`ifdef GC_REF_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int    due;
    data_t data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  always #5 clk = ~clk;

  gc_dram_refresh_ctrl_if bus();

  gc_dram_refresh_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Macro model: registered read port, write port, no re/we collision handling needed.
  data_t mmem [ROWS];
  data_t mrd = '0;
  data_t gold [ROWS];
  assign bus.mem_rd = mrd;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < ROWS; i++) mmem[i] <= gold[i];
    end else begin
      if (bus.mem_re) mrd <= mmem[bus.mem_raddr];
      if (bus.mem_we) mmem[bus.mem_waddr] <= bus.mem_in;
    end
  end

  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    abs_cyc = 0;
  int    mrow = 0;
  addr_t slot_row = '0;
  bit    slot_skip = 1'b0;
  bit    mwritten [ROWS];
  rsp_t  rq [$];

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(dut.tick && dut.ref_pending)) else begin
        n_fail++;
        $display("FAIL tick_while_pending at cycle %0d", cyc);
      end
    end
  end

  // Advance one clock; cyc counts cycles since reset release, slot k begins at cycle RP*k.
  task automatic tick();
    bit r;
    @(posedge clk);
    r = rst_n;
    #1;
    abs_cyc++;
    if (!r) begin
      cyc = 0;
      mrow = 0;
      slot_skip = 1'b0;
      for (int i = 0; i < ROWS; i++) mwritten[i] = 1'b0;
      rq.delete();
    end else begin
      cyc++;
      if (cyc >= RP && cyc % RP == 0) begin
        slot_row = addr_t'(mrow);
        mrow = (mrow + 1) % ROWS;
        slot_skip = SKIP && mwritten[slot_row];
        mwritten[slot_row] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.u_req_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Present a request from just after a posedge; returns at the negedge of the accepting cycle.
  task automatic do_req(input bit we, input addr_t a, input data_t d, output bit ok);
    bus.u_req_valid = 1'b1;
    bus.u_we = we;
    bus.u_addr = a;
    bus.u_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (bus.u_req_ready === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.mem_re, bus.mem_we, bus.ref_busy, bus.u_rvalid} !== 4'b0000)
      $display("FAIL reset_ctrl: re/we/busy/rvalid=%b want 0000",
               {bus.mem_re, bus.mem_we, bus.ref_busy, bus.u_rvalid});
    n_tests++;
    if (bus.u_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", bus.u_rdata);
    n_tests++;
    if ({bus.mem_raddr, bus.mem_waddr, bus.mem_in} !== '0)
      $display("FAIL reset_bus: raddr %h waddr %h in %h want 0", bus.mem_raddr, bus.mem_waddr, bus.mem_in);
    n_tests++;
    if (bus.u_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.u_req_ready);
    if (n_fail != 0 || n_tests != 4) n_fail += 0;
    n_fail += ((bus.mem_re | bus.mem_we | bus.ref_busy | bus.u_rvalid) !== 1'b0) ? 1 : 0;
    n_fail += (bus.u_rdata !== '0) ? 1 : 0;
    n_fail += ({bus.mem_raddr, bus.mem_waddr, bus.mem_in} !== '0) ? 1 : 0;
    n_fail += (bus.u_req_ready !== 1'b1) ? 1 : 0;
  endtask

  task automatic test_refresh_sweep();
    int    first_re = -1;
    int    bad = 0;
    addr_t rows [$];
    while (cyc < RP * (ROWS + 1) + 3) begin
      tick();
      @(negedge clk);
      if (bus.mem_re === 1'b1 && bus.mem_we === 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL sweep_collision: re and we both high at cycle %0d", cyc);
      end
      if (bus.mem_re === 1'b1) begin
        if (first_re < 0) first_re = cyc;
        rows.push_back(bus.mem_raddr);
      end
      if (bus.mem_we === 1'b1) begin
        n_tests++;
        if (rows.size() == 0 || bus.mem_waddr !== rows[rows.size()-1] ||
            bus.mem_in !== bus.mem_rd || bus.mem_in !== gold[bus.mem_waddr]) begin
          n_fail++;
          $display("FAIL sweep_writeback: cycle %0d waddr %h in %h want row of prior read, data %h",
                   cyc, bus.mem_waddr, bus.mem_in, gold[bus.mem_waddr]);
        end
      end
    end
    n_tests++;
    if (first_re != RP + 1) begin
      n_fail++;
      $display("FAIL first_refresh_cycle: got %0d want %0d", first_re, RP + 1);
    end
    n_tests++;
    if (rows.size() != ROWS + 1) begin
      n_fail++;
      $display("FAIL refresh_count: got %0d want %0d", rows.size(), ROWS + 1);
    end else begin
      for (int i = 0; i < rows.size(); i++) if (rows[i] !== addr_t'(i % ROWS)) bad++;
      n_tests++;
      if (rows[0] !== '0 || rows[ROWS-1] !== addr_t'(ROWS-1) || rows[ROWS] !== '0 || bad != 0) begin
        n_fail++;
        $display("FAIL refresh_wrap: first %h row127 %h next %h (%0d out of order) want 0,7f,0",
                 rows[0], rows[ROWS-1], rows[ROWS], bad);
      end
    end
  endtask

  task automatic test_stall();
    int guard = 0;
    while (cyc % RP != RP - 1 && guard < 2 * RP) begin
      tick();
      guard++;
    end
    tick();
    bus.u_req_valid = 1'b1; bus.u_we = 1'b0; bus.u_addr = 7; bus.u_wdata = '0;
    @(negedge clk);
    n_tests++;
    if ({bus.u_req_ready, bus.ref_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_pending: ready/busy=%b want 00", {bus.u_req_ready, bus.ref_busy});
    end
    tick(); @(negedge clk);
    n_tests++;
    if ({bus.u_req_ready, bus.mem_re, bus.ref_busy, bus.mem_raddr} !== {3'b011, slot_row}) begin
      n_fail++;
      $display("FAIL stall_ref_rd: ready/re/busy=%b raddr %h want 011 raddr %h",
               {bus.u_req_ready, bus.mem_re, bus.ref_busy}, bus.mem_raddr, slot_row);
    end
    tick(); @(negedge clk);
    n_tests++;
    if ({bus.u_req_ready, bus.mem_we, bus.mem_re, bus.ref_busy} !== 4'b0101) begin
      n_fail++;
      $display("FAIL stall_ref_wb: ready/we/re/busy=%b want 0101",
               {bus.u_req_ready, bus.mem_we, bus.mem_re, bus.ref_busy});
    end
    tick(); @(negedge clk);
    n_tests++;
    if ({bus.u_req_ready, bus.mem_re, bus.mem_raddr} !== {2'b11, addr_t'(7)}) begin
      n_fail++;
      $display("FAIL stall_accept: ready/re=%b raddr %h want 11 raddr 07",
               {bus.u_req_ready, bus.mem_re}, bus.mem_raddr);
    end
    tick();
    bus.u_req_valid = 1'b0;
    @(negedge clk);
    tick(); @(negedge clk);
    n_tests++;
    if (bus.u_rvalid !== 1'b1 || bus.u_rdata !== gold[7]) begin
      n_fail++;
      $display("FAIL stall_rdata: rvalid %b data %h want 1 %h", bus.u_rvalid, bus.u_rdata, gold[7]);
    end
  endtask

  task automatic test_write_read();
    data_t dv = 64'hDEADBEEF_CAFEF00D;
    bit    ok;
    tick();
    do_req(1'b1, 5, dv, ok);
    n_tests++;
    if (!ok || {bus.mem_we, bus.mem_re, bus.mem_waddr, bus.mem_in} !== {2'b10, addr_t'(5), dv}) begin
      n_fail++;
      $display("FAIL wr_issue: ok %b we/re=%b waddr %h in %h want 10 05 %h",
               ok, {bus.mem_we, bus.mem_re}, bus.mem_waddr, bus.mem_in, dv);
    end
    gold[5] = dv;
    mwritten[5] = 1'b1;
    tick();
    do_req(1'b0, 5, '0, ok);
    n_tests++;
    if (!ok || {bus.mem_re, bus.mem_we, bus.mem_raddr} !== {2'b10, addr_t'(5)}) begin
      n_fail++;
      $display("FAIL rd_issue: ok %b re/we=%b raddr %h want 10 05", ok, {bus.mem_re, bus.mem_we}, bus.mem_raddr);
    end
    tick();
    bus.u_req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.u_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_early: rvalid %b one cycle after accept, want 0", bus.u_rvalid);
    end
    tick(); @(negedge clk);
    n_tests++;
    if (bus.u_rvalid !== 1'b1 || bus.u_rdata !== dv) begin
      n_fail++;
      $display("FAIL rd_data: rvalid %b data %h want 1 %h", bus.u_rvalid, bus.u_rdata, dv);
    end
    tick(); @(negedge clk);
    n_tests++;
    if (bus.u_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_pulse: rvalid %b three cycles after accept, want 0", bus.u_rvalid);
    end
  endtask

  task automatic test_reset_mid_refresh();
    bit ok;
    int bad = 0;
    do_reset();
    tick();
    do_req(1'b0, 5, '0, ok);
    tick();
    bus.u_req_valid = 1'b0;
    while (cyc < RP + 1) begin
      tick();
      @(negedge clk);
    end
    n_tests++;
    if ({bus.mem_re, bus.mem_raddr} !== {1'b1, addr_t'(0)} || bus.u_rdata !== gold[5]) begin
      n_fail++;
      $display("FAIL mid_pre: re %b raddr %h rdata %h want 1 00 %h", bus.mem_re, bus.mem_raddr, bus.u_rdata, gold[5]);
    end
    rst_n = 1'b0;
    tick(); @(negedge clk);
    n_tests++;
    if ({bus.mem_re, bus.mem_we, bus.ref_busy, bus.u_rvalid, bus.u_req_ready} !== 5'b00001 ||
        bus.u_rdata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: re/we/busy/rvalid/ready=%b rdata %h want 00001 0",
               {bus.mem_re, bus.mem_we, bus.ref_busy, bus.u_rvalid, bus.u_req_ready}, bus.u_rdata);
    end
    rst_n = 1'b1;
    while (cyc < RP + 2) begin
      tick();
      @(negedge clk);
      if (cyc < RP + 1 && (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0)) bad++;
      if (cyc == RP + 1 && {bus.mem_re, bus.mem_raddr} !== {1'b1, addr_t'(0)}) bad++;
      if (cyc == RP + 2 && {bus.mem_we, bus.mem_waddr} !== {1'b1, addr_t'(0)}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_restart: %0d cycles off the row-0 restart schedule, want 0", bad);
    end
  endtask

  task automatic test_skip_written();
    bit    ok;
    data_t dv = {$urandom, $urandom};
    do_reset();
    tick();
    do_req(1'b1, 0, dv, ok);
    gold[0] = dv;
    mwritten[0] = 1'b1;
    tick();
    bus.u_req_valid = 1'b0;
    while (cyc < 2 * RP + 1) begin
      tick();
      @(negedge clk);
      if (cyc == RP) begin
        n_tests++;
        if ({bus.u_req_ready, bus.ref_busy} !== {SKIP, 1'b0}) begin
          n_fail++;
          $display("FAIL skip_slot_ready: ready/busy=%b want %b0", {bus.u_req_ready, bus.ref_busy}, SKIP);
        end
      end
      if (cyc == RP + 1) begin
        n_tests++;
        if (bus.mem_re !== !SKIP) begin
          n_fail++;
          $display("FAIL skip_slot_rd: re %b want %b", bus.mem_re, !SKIP);
        end
      end
      if (cyc == RP + 2) begin
        n_tests++;
        if (bus.mem_we !== !SKIP || (!SKIP && bus.mem_in !== dv)) begin
          n_fail++;
          $display("FAIL skip_slot_wb: we %b in %h want %b %h", bus.mem_we, bus.mem_in, !SKIP, dv);
        end
      end
    end
    n_tests++;
    if ({bus.mem_re, bus.mem_raddr} !== {1'b1, addr_t'(1)}) begin
      n_fail++;
      $display("FAIL skip_next_row: re %b raddr %h want 1 01", bus.mem_re, bus.mem_raddr);
    end
  endtask

  task automatic test_soak();
    int    last_w [ROWS];
    bit    v, we, acc, act, er, erv;
    addr_t a;
    data_t d;
    int    p, oldest;
    logic [2*AW+WIDTH+1:0] exp_bus, got_bus;
    do_reset();
    for (int i = 0; i < ROWS; i++) last_w[i] = abs_cyc;
    repeat (20000) begin
      tick();
      v = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a = addr_t'($urandom_range(0, ROWS - 1));
      d = {$urandom, $urandom};
      bus.u_req_valid = v; bus.u_we = we; bus.u_addr = a; bus.u_wdata = d;
      @(negedge clk);
      p = cyc % RP;
      act = (cyc >= RP) && (p <= 2) && !slot_skip;
      er = !act;
      acc = v && er;
      n_tests++;
      if (bus.u_req_ready !== er || bus.ref_busy !== (act && p != 0)) begin
        n_fail++;
        $display("FAIL soak_ready: cycle %0d ready/busy=%b%b want %b%b", cyc,
                 bus.u_req_ready, bus.ref_busy, er, act && p != 0);
      end
      exp_bus = {(act && p == 1) || (acc && !we), (act && p == 2) || (acc && we),
                 (act && p == 1) ? slot_row : (acc && !we) ? a : addr_t'(0),
                 (act && p == 2) ? slot_row : (acc && we) ? a : addr_t'(0),
                 (act && p == 2) ? gold[slot_row] : (acc && we) ? d : data_t'(0)};
      got_bus = {bus.mem_re, bus.mem_we, bus.mem_raddr, bus.mem_waddr, bus.mem_in};
      n_tests++;
      if (got_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL soak_macro: cycle %0d re,we,raddr,waddr,in=%h want %h", cyc, got_bus, exp_bus);
      end
      while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
      erv = (rq.size() > 0) && (rq[0].due == cyc);
      n_tests++;
      if (bus.u_rvalid !== erv || $isunknown(bus.u_rdata) || (erv && bus.u_rdata !== rq[0].data)) begin
        n_fail++;
        $display("FAIL soak_resp: cycle %0d rvalid %b rdata %h want %b %h", cyc,
                 bus.u_rvalid, bus.u_rdata, erv, erv ? rq[0].data : data_t'(0));
      end
      if (erv) void'(rq.pop_front());
      if (acc && we) begin
        gold[a] = d;
        mwritten[a] = 1'b1;
      end else if (acc) begin
        rq.push_back('{due: cyc + 2, data: gold[a]});
      end
      if (bus.mem_we === 1'b1) last_w[bus.mem_waddr] = abs_cyc;
      oldest = 0;
      for (int i = 0; i < ROWS; i++) if (abs_cyc - last_w[i] > oldest) oldest = abs_cyc - last_w[i];
      n_tests++;
      if (oldest >= RETENTION) begin
        n_fail++;
        $display("FAIL soak_retention: cycle %0d oldest row age %0d want < %0d", cyc, oldest, RETENTION);
      end
    end
    bus.u_req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) begin
      gold[i] = {$urandom, $urandom};
      mwritten[i] = 1'b0;
    end
    bus.u_req_valid = 1'b0;
    bus.u_we = 1'b0;
    bus.u_addr = '0;
    bus.u_wdata = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    test_reset();
    test_refresh_sweep();
    test_stall();
    test_write_read();
    test_reset_mid_refresh();
    test_skip_written();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
